ps2_kbd_rx: RTL and testbench

Parametrised PS/2 keyboard receiver and the successor to the single-byte PS/2 receiver. It deserialises 11-bit device-to-host frames and decodes the 0xE0 (extended) and 0xF0 (break) prefixes into complete key events. Events are buffered in a FIFO with a valid/ready handshake. It sits between the board PS/2 pins and the keyboard MMIO/device layer. It adds frame timeout recovery, error reporting and overflow tracking.

---
 rtl/ps2_kbd_rx.sv | 179 +++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix decoder, event FIFO.
// Optional ps2_clk glitch filter enabled by defining PS2_DEGLITCH_EN.
module ps2_kbd_rx #(
    parameter int FIFO_DEPTH      = 8,
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int DEGLITCH_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_release,
    output logic                          evt_extended,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    logic       clk_s1, clk_s2, data_s1, data_s2;
    logic       clk_lvl, clk_prev, samp;
    logic [3:0] cnt;
    logic [9:0] shreg;
    logic [TW-1:0] tmo;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_ok;
    state_t     state, state_n;
    logic       push;
    logic [9:0] evt_in;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop, full, wr_en, drop;
    logic [9:0]    head;

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

`ifdef PS2_DEGLITCH_EN
    localparam int DW = $clog2(DEGLITCH_CYCLES + 1);
    logic [DW-1:0] dg_cnt;

    // The filtered level follows the pin only after DEGLITCH_CYCLES disagreeing cycles in a row.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_lvl <= 1'b1;
            dg_cnt  <= '0;
        end else if (clk_s2 != clk_lvl) begin
            if (dg_cnt == DW'(DEGLITCH_CYCLES - 1)) begin
                clk_lvl <= clk_s2;
                dg_cnt  <= '0;
            end else begin
                dg_cnt <= dg_cnt + 1'b1;
            end
        end else begin
            dg_cnt <= '0;
        end
    end
`else
    assign clk_lvl = clk_s2;
`endif

    assign samp = clk_prev & ~clk_lvl;
    // At the stop-bit strobe shreg holds bits 0..9 with the start bit at index 0.
    assign frame_ok = ~shreg[0] & data_s2 & (^shreg[9:1]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_prev   <= 1'b1;
            cnt        <= '0;
            shreg      <= '0;
            tmo        <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            clk_prev   <= clk_lvl;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (samp) begin
                tmo <= '0;
                if (cnt == 4'd10) begin
                    cnt        <= '0;
                    byte_valid <= frame_ok;
                    frame_err  <= ~frame_ok;
                    byte_data  <= shreg[8:1];
                end else begin
                    shreg <= {data_s2, shreg[9:1]};
                    cnt   <= cnt + 4'd1;
                end
            end else if (cnt == 4'd0) begin
                tmo <= '0;
            end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo       <= '0;
                cnt       <= '0;
                frame_err <= 1'b1;
            end else begin
                tmo <= tmo + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        push    = 1'b0;
        evt_in  = {(state == EXT) || (state == EXT_BRK),
                   (state == BRK) || (state == EXT_BRK), byte_data};
        if (frame_err) begin
            state_n = IDLE;
        end else if (byte_valid) begin
            if (byte_data == 8'hE0) begin
                state_n = ((state == BRK) || (state == EXT_BRK)) ? EXT_BRK : EXT;
            end else if (byte_data == 8'hF0) begin
                state_n = ((state == EXT) || (state == EXT_BRK)) ? EXT_BRK : BRK;
            end else begin
                push    = 1'b1;
                state_n = IDLE;
            end
        end
    end

    assign full  = (fifo_count == (AW + 1)'(FIFO_DEPTH));
    assign pop   = evt_valid & evt_ready;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= evt_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    assign evt_valid    = (fifo_count != '0);
    assign head         = evt_valid ? mem[rd_ptr] : 10'd0;
    assign evt_code     = head[7:0];
    assign evt_release  = head[8];
    assign evt_extended = head[9];
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - directed self-checking bench for ps2_kbd_rx.
module tb_ps2_kbd_rx;
    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int HALF  = 20;
`ifdef PS2_DEGLITCH_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       evt_valid, evt_ready = 1'b0;
    logic [7:0] evt_code;
    logic       evt_release, evt_extended;
    logic [3:0] fifo_count;
    logic       overflow, overflow_clr = 1'b0, frame_err;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int err_wide = 0;
    logic err_prev = 1'b0;

    ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .DEGLITCH_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_release(evt_release), .evt_extended(evt_extended),
        .fifo_count(fifo_count), .overflow(overflow), .overflow_clr(overflow_clr),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (frame_err && err_prev) err_wide++;
        err_prev = frame_err;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic [10:0] f;
        f = frame_bits(d, bad_par, bad_stop);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    // Sends bits 0..9 and drops ps2_clk for the stop bit, leaving the caller at that edge.
    task automatic send_head(input logic [7:0] d);
        logic [10:0] f;
        f = frame_bits(d, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
    endtask

    task automatic pop_evt(output logic [10:0] got);
        got = {evt_valid, evt_extended, evt_release, evt_code};
        evt_ready = 1'b1;
        wait_cyc(1);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        wait_cyc(3);
        tests++;
        if ({evt_valid, fifo_count, overflow, frame_err, evt_code, evt_release, evt_extended} !== 19'd0) begin
            fails++;
            $display("FAIL reset_state: got v=%b cnt=%0d ovf=%b err=%b code=%h, want all zero",
                     evt_valid, fifo_count, overflow, frame_err, evt_code);
        end
        reset = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_basic;
        logic [10:0] got;
        send_head(8'h1C);
        wait_cyc(3 + LAT);
        tests++;
        if (evt_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: evt_valid=%b, want 0", evt_valid);
        end
        wait_cyc(1);
        tests++;
        if ({evt_valid, evt_extended, evt_release, evt_code, fifo_count} !== {11'h41C, 4'd1}) begin
            fails++;
            $display("FAIL latency_event: got v=%b ext=%b rel=%b code=%h cnt=%0d, want v=1 ext=0 rel=0 code=1c cnt=1",
                     evt_valid, evt_extended, evt_release, evt_code, fifo_count);
        end
        wait_cyc(HALF - 4 - LAT);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        pop_evt(got);
        tests++;
        if ({evt_valid, fifo_count} !== 5'd0) begin
            fails++;
            $display("FAIL basic_pop: got v=%b cnt=%0d, want v=0 cnt=0", evt_valid, fifo_count);
        end
    endtask

    task automatic test_prefixes;
        logic [7:0]  bytes [7] = '{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        logic [10:0] exp [3] = '{11'h51C, 11'h675, 11'h775};
        logic [10:0] got;
        int e0;
        e0 = err_cnt;
        foreach (bytes[i]) send_byte(bytes[i], 1'b0, 1'b0);
        tests++;
        if (fifo_count !== 4'd3 || err_cnt != e0) begin
            fails++;
            $display("FAIL prefix_count: got cnt=%0d errs=%0d, want cnt=3 errs=0", fifo_count, err_cnt - e0);
        end
        foreach (exp[i]) begin
            pop_evt(got);
            tests++;
            if (got !== exp[i]) begin
                fails++;
                $display("FAIL prefix_evt%0d: got %h, want %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_frame_errors;
        logic [10:0] got;
        int e0;
        e0 = err_cnt;
        send_byte(8'h1C, 1'b1, 1'b0);
        tests++;
        if (err_cnt != e0 + 1 || fifo_count !== 4'd0) begin
            fails++;
            $display("FAIL parity_err: got errs=%0d cnt=%0d, want errs=1 cnt=0", err_cnt - e0, fifo_count);
        end
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h1C, 1'b0, 1'b1);
        send_byte(8'h1C, 1'b0, 1'b0);
        tests++;
        if (err_cnt != e0 + 2) begin
            fails++;
            $display("FAIL stop_err: got errs=%0d, want 2", err_cnt - e0);
        end
        pop_evt(got);
        tests++;
        if (got !== 11'h41C) begin
            fails++;
            $display("FAIL brk_discard: got %h, want 41c", got);
        end
    endtask

    task automatic test_timeout;
        logic [10:0] f;
        logic [10:0] got;
        int e0;
        f = frame_bits(8'h32, 1'b0, 1'b0);
        e0 = err_cnt;
        for (int i = 0; i < 6; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        wait_cyc(TMO + 20);
        tests++;
        if (err_cnt != e0 + 1 || fifo_count !== 4'd0) begin
            fails++;
            $display("FAIL timeout_err: got errs=%0d cnt=%0d, want errs=1 cnt=0", err_cnt - e0, fifo_count);
        end
        send_byte(8'h32, 1'b0, 1'b0);
        pop_evt(got);
        tests++;
        if (got !== 11'h432) begin
            fails++;
            $display("FAIL timeout_recover: got %h, want 432", got);
        end
    endtask

    task automatic test_overflow;
        logic [10:0] got;
        for (int i = 0; i <= DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
        tests++;
        if (fifo_count !== 4'(DEPTH) || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_full: got cnt=%0d ovf=%b, want cnt=%0d ovf=1", fifo_count, overflow, DEPTH);
        end
        overflow_clr = 1'b1;
        wait_cyc(1);
        overflow_clr = 1'b0;
        tests++;
        if (overflow !== 1'b0 || evt_code !== 8'h10) begin
            fails++;
            $display("FAIL ovf_clr: got ovf=%b head=%h, want ovf=0 head=10", overflow, evt_code);
        end
        send_head(8'h20);
        wait_cyc(3 + LAT);
        evt_ready = 1'b1;
        wait_cyc(1);
        evt_ready = 1'b0;
        tests++;
        if (fifo_count !== 4'(DEPTH) || overflow !== 1'b0) begin
            fails++;
            $display("FAIL push_pop_full: got cnt=%0d ovf=%b, want cnt=%0d ovf=0", fifo_count, overflow, DEPTH);
        end
        wait_cyc(HALF - 4 - LAT);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        for (int i = 0; i < DEPTH; i++) begin
            pop_evt(got);
            tests++;
            if (got !== ((i == DEPTH - 1) ? 11'h420 : 11'h411 + 11'(i))) begin
                fails++;
                $display("FAIL drain%0d: got %h, want %h", i, got,
                         (i == DEPTH - 1) ? 11'h420 : 11'h411 + 11'(i));
            end
        end
        tests++;
        if (fifo_count !== 4'd0) begin
            fails++;
            $display("FAIL drain_empty: got cnt=%0d, want 0", fifo_count);
        end
    endtask

    task automatic test_mid_reset;
        logic [10:0] f;
        logic [10:0] got;
        send_byte(8'h1C, 1'b0, 1'b0);
        send_byte(8'hE0, 1'b0, 1'b0);
        f = frame_bits(8'h6B, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(f[i]);
        reset = 1'b0;
        wait_cyc(1);
        tests++;
        if ({evt_valid, fifo_count, overflow, frame_err, evt_code, evt_release, evt_extended} !== 19'd0) begin
            fails++;
            $display("FAIL mid_reset: got v=%b cnt=%0d ovf=%b err=%b code=%h, want all zero",
                     evt_valid, fifo_count, overflow, frame_err, evt_code);
        end
        reset = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(HALF);
        send_byte(8'h1C, 1'b0, 1'b0);
        pop_evt(got);
        tests++;
        if (got !== 11'h41C || fifo_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_recover: got %h cnt=%0d, want 41c cnt=0", got, fifo_count);
        end
    endtask

`ifdef PS2_DEGLITCH_EN
    task automatic test_deglitch;
        logic [10:0] got;
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        send_byte(8'h1C, 1'b0, 1'b0);
        pop_evt(got);
        tests++;
        if (got !== 11'h41C) begin
            fails++;
            $display("FAIL deglitch: got %h, want 41c", got);
        end
    endtask
`endif

    task automatic test_err_width;
        tests++;
        if (err_wide != 0) begin
            fails++;
            $display("FAIL err_width: got %0d multi-cycle pulses, want 0", err_wide);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefixes();
        test_frame_errors();
        test_timeout();
        test_overflow();
        test_mid_reset();
`ifdef PS2_DEGLITCH_EN
        test_deglitch();
`endif
        test_err_width();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
